read_block_scheduler: RTL and testbench
=======================================

READ_BLOCK_SCHEDULER -- requirements
Module: read_block_scheduler

Interface
REQ-001 SHALL have parameter BLOCK_LEN, default 256, giving read_req high-time per line in clk cycles (range 2..65535).
REQ-002 SHALL have parameter GAP_CYCLES, default 4, giving idle cycles before each read burst (range 1..255).
REQ-003 SHALL have parameter LINES_PER_FRAME, default 3072, giving lines per frame (range 1..65535).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 65535, giving the ARM-state watchdog limit (used only with the macro in REQ-030).
REQ-005 SHALL have port clk  in  1  clock, shared with the reorder read port.
REQ-006 SHALL have port sync_rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port enable  in  1  scheduler enable.
REQ-008 SHALL have port frame_start  in  1  single-cycle frame start pulse.
REQ-009 SHALL have port block_done  in  1  single-cycle pulse, one block written; already synchronous to clk.
REQ-010 SHALL have port out_ready  in  1  downstream can accept one line.
REQ-011 SHALL have port read_req  out  1  read burst request to the reorder buffer.
REQ-012 SHALL have port rd_bank  out  1  bank being read; toggles per line.
REQ-013 SHALL have port line_cnt  out  16  completed lines in current frame.
REQ-014 SHALL have port pending  out  2  written-but-unread blocks (0..2).
REQ-015 SHALL have ports busy, frame_done, overflow_err, timeout_err  out  1 each: state != IDLE; 1-cycle end-of-frame pulse; sticky overflow; sticky watchdog.

Function
REQ-016 SHALL implement states IDLE, ARM, GAP, READ, ENDL, all transitions on posedge clk.
REQ-017 IDLE: on enable && frame_start SHALL clear line_cnt, pending, rd_bank and go to ARM; block_done in IDLE is ignored.
REQ-018 ARM: when pending != 0 && out_ready SHALL decrement pending and go to GAP; otherwise hold.
REQ-019 GAP: SHALL hold read_req low exactly GAP_CYCLES cycles, then go to READ.
REQ-020 READ: read_req SHALL be registered high for exactly BLOCK_LEN consecutive cycles, then go to ENDL; read_req first high GAP_CYCLES+1 edges after the edge sampling the ARM condition.
REQ-021 ENDL: one cycle, read_req low; SHALL increment line_cnt, toggle rd_bank; if new line_cnt == LINES_PER_FRAME, pulse frame_done and go to IDLE, else go to ARM.
REQ-022 pending: block_done increments, ARM consume decrements; simultaneous both leaves pending unchanged.
REQ-023 block_done with pending == 2 and no same-cycle consume SHALL set overflow_err and keep pending at 2.
REQ-024 enable low in ARM SHALL go to IDLE next cycle; enable low in GAP/READ/ENDL SHALL complete the current line (read_req never truncated), then go to IDLE instead of ARM, with no frame_done.
REQ-025 frame_start outside IDLE SHALL be ignored.
REQ-026 line_cnt arithmetic 16-bit; never exceeds LINES_PER_FRAME.

Reset
REQ-027 sync_rst high SHALL asynchronously force IDLE; read_req, rd_bank, frame_done, overflow_err, timeout_err = 0; line_cnt = 0; pending = 0; all internal counters = 0.
REQ-028 sync_rst mid-burst SHALL drop read_req immediately; first rising clk after release resumes in IDLE.
REQ-029 Sticky errors SHALL clear only by sync_rst.

Configuration
REQ-030 Macro RD_SCHED_WATCHDOG_EN defined: consecutive cycles in ARM exceeding TIMEOUT_CYCLES SHALL set timeout_err and go to IDLE; counter clears on leaving ARM.
REQ-031 Macro undefined: no watchdog logic, timeout_err tied 0, ARM waits indefinitely.

Verification (BLOCK_LEN=8, GAP_CYCLES=2, LINES_PER_FRAME=3)
REQ-032 Reset mid-READ at burst cycle 4 -> read_req 0 same cycle, state IDLE, line_cnt 0, pending 0.
REQ-033 frame_start, 3 block_done pulses spaced 20 cycles, out_ready=1 -> 3 bursts of exactly 8 high cycles, each preceded by 2 low, rd_bank 0,1,0, frame_done 1 cycle after 3rd ENDL, line_cnt 3.
REQ-034 block_done and ARM consume same cycle with pending=1 -> pending stays 1, next burst follows.
REQ-035 out_ready=0, 3 block_done pulses -> pending 2, overflow_err 1 on 3rd pulse, remains 1 after out_ready=1 and frame end.
REQ-036 enable deasserted at READ cycle 3 -> read_req stays high through cycle 8, then IDLE, line_cnt 1, no frame_done.
REQ-037 RD_SCHED_WATCHDOG_EN, TIMEOUT_CYCLES=16, no block_done after frame_start -> timeout_err 1 after 17 ARM cycles, state IDLE; without macro timeout_err stays 0 and busy stays 1.

Source files
------------

// File: rtl/read_block_scheduler_if.sv
// read_block_scheduler_if
//   Bundles the scheduler's control inputs and status outputs.
//   master : frame controller side (drives enable/frame_start/block_done/out_ready)
//   slave  : scheduler side (drives read_req/rd_bank/line_cnt/pending/status)
interface read_block_scheduler_if;
  logic        enable;
  logic        frame_start;
  logic        block_done;
  logic        out_ready;
  logic        read_req;
  logic        rd_bank;
  logic [15:0] line_cnt;
  logic [1:0]  pending;
  logic        busy;
  logic        frame_done;
  logic        overflow_err;
  logic        timeout_err;

  modport master (
    output enable, frame_start, block_done, out_ready,
    input  read_req, rd_bank, line_cnt, pending, busy, frame_done,
           overflow_err, timeout_err
  );

  modport slave (
    input  enable, frame_start, block_done, out_ready,
    output read_req, rd_bank, line_cnt, pending, busy, frame_done,
           overflow_err, timeout_err
  );
endinterface

// File: rtl/read_block_scheduler.sv
// read_block_scheduler
//   Paces line read bursts out of a two-bank reorder buffer. Each written
//   block (block_done) becomes pending; when downstream is ready the
//   scheduler consumes one, waits a gap, then raises read_req for exactly
//   BLOCK_LEN cycles, alternating rd_bank per line, until LINES_PER_FRAME
//   lines have been read.
// Ports
//   clk      : clock (shared with the reorder read port)
//   sync_rst : asynchronous active-high reset
//   bus      : read_block_scheduler_if.slave
//              in : enable, frame_start, block_done, out_ready
//              out: read_req, rd_bank, line_cnt[15:0], pending[1:0], busy,
//                   frame_done, overflow_err, timeout_err
// Build option
//   RD_SCHED_WATCHDOG_EN : when defined, a stall in ARM longer than
//   TIMEOUT_CYCLES sets timeout_err and returns to IDLE. When undefined,
//   timeout_err is tied low and ARM waits indefinitely.
module read_block_scheduler #(
  parameter int unsigned BLOCK_LEN       = 256,
  parameter int unsigned GAP_CYCLES      = 4,
  parameter int unsigned LINES_PER_FRAME = 3072,
  parameter int unsigned TIMEOUT_CYCLES  = 65535
) (
  input  logic                 clk,
  input  logic                 sync_rst,
  read_block_scheduler_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ARM, GAP, READ, ENDL} state_t;

  localparam logic [15:0] READ_LAST = 16'(BLOCK_LEN - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES);
  localparam logic [15:0] LPF       = 16'(LINES_PER_FRAME);

  state_t      state;
  logic [15:0] cnt;          // shared GAP / READ cycle counter
  logic        stop_req;     // enable dropped mid-line: finish line, then IDLE
  logic        read_req_q;
  logic        rd_bank_q;
  logic [15:0] line_cnt_q;
  logic [1:0]  pending_q;
  logic        frame_done_q;
  logic        overflow_q;
  logic        timeout_q;
  logic        consume;
  logic [15:0] line_nxt;

  // A block is consumed only on the ARM cycle that actually launches a line;
  // enable low in ARM takes priority and aborts to IDLE instead.
  assign consume  = (state == ARM) && bus.enable && (pending_q != 2'd0) && bus.out_ready;
  assign line_nxt = line_cnt_q + 16'd1;

`ifdef RD_SCHED_WATCHDOG_EN
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES);
  logic [15:0] wd_cnt;
`endif

  always_ff @(posedge clk or posedge sync_rst) begin
    if (sync_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      stop_req     <= 1'b0;
      read_req_q   <= 1'b0;
      rd_bank_q    <= 1'b0;
      line_cnt_q   <= '0;
      pending_q    <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      timeout_q    <= 1'b0;
`ifdef RD_SCHED_WATCHDOG_EN
      wd_cnt       <= '0;
`endif
    end else begin
      frame_done_q <= 1'b0;

      // Block bookkeeping runs only inside a frame; IDLE ignores block_done.
      // Write and consume in the same cycle cancel out.
      if (state != IDLE) begin
        if (bus.block_done && !consume) begin
          if (pending_q == 2'd2) overflow_q <= 1'b1;
          else                   pending_q  <= pending_q + 2'd1;
        end else if (!bus.block_done && consume) begin
          pending_q <= pending_q - 2'd1;
        end
      end

      if ((state == GAP || state == READ) && !bus.enable) stop_req <= 1'b1;

`ifdef RD_SCHED_WATCHDOG_EN
      if (state != ARM) wd_cnt <= '0;
`endif

      case (state)
        IDLE: begin
          if (bus.enable && bus.frame_start) begin
            line_cnt_q <= '0;
            pending_q  <= '0;
            rd_bank_q  <= 1'b0;
            stop_req   <= 1'b0;
            state      <= ARM;
          end
        end
        ARM: begin
          if (!bus.enable) begin
            state <= IDLE;
          end else if (consume) begin
            cnt   <= '0;
            state <= GAP;
          end
`ifdef RD_SCHED_WATCHDOG_EN
          else if (wd_cnt == WD_LIMIT) begin
            timeout_q <= 1'b1;
            state     <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
`endif
        end
        // The consume edge itself counts as the first GAP cycle, so read_req
        // rises GAP_CYCLES+1 edges after the ARM decision.
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt        <= '0;
            read_req_q <= 1'b1;
            state      <= READ;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        READ: begin
          if (cnt == READ_LAST) begin
            cnt        <= '0;
            read_req_q <= 1'b0;
            state      <= ENDL;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ENDL: begin
          line_cnt_q <= line_nxt;
          rd_bank_q  <= ~rd_bank_q;
          stop_req   <= 1'b0;
          if (stop_req || !bus.enable) begin
            state <= IDLE;
          end else if (line_nxt == LPF) begin
            frame_done_q <= 1'b1;
            state        <= IDLE;
          end else begin
            state <= ARM;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.read_req     = read_req_q;
  assign bus.rd_bank      = rd_bank_q;
  assign bus.line_cnt     = line_cnt_q;
  assign bus.pending      = pending_q;
  assign bus.busy         = (state != IDLE);
  assign bus.frame_done   = frame_done_q;
  assign bus.overflow_err = overflow_q;
  assign bus.timeout_err  = timeout_q;

endmodule

// File: tb/tb_read_block_scheduler.sv
module tb_read_block_scheduler;
  localparam int BL  = 8;
  localparam int GC  = 2;
  localparam int LPF = 3;
  localparam int TO  = 16;

  logic clk = 1'b0;
  logic sync_rst;

  read_block_scheduler_if bus();

  read_block_scheduler #(
    .BLOCK_LEN(BL), .GAP_CYCLES(GC), .LINES_PER_FRAME(LPF), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .sync_rst(sync_rst), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct { int bank; int len; } burst_t;
  burst_t burst_q[$];
  int     fd_q[$];
  int     n_cmp = 0;
  int     n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  task automatic pulse_bd();
    bus.block_done = 1'b1;
    tick();
    bus.block_done = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_burst(input int bank, input int len);
    burst_t b;
    b.bank = bank;
    b.len  = len;
    burst_q.push_back(b);
  endtask

  // Edges until read_req is seen high, bounded.
  task automatic wait_rr(output int n);
    n = 0;
    while (!bus.read_req && n < 60) begin
      tick();
      n++;
    end
    if (!bus.read_req) check("read_req_wait_timeout", 0, 1);
  endtask

  // Monitor: measures each read_req burst and each frame_done pulse and
  // compares against the scoreboard queues.
  initial begin
    int     len = 0;
    int     bank = 0;
    bit     in_burst = 0;
    bit     fd_prev = 0;
    burst_t e;
    forever begin
      @(negedge clk);
      if (bus.read_req) begin
        if (!in_burst) begin
          in_burst = 1;
          len  = 0;
          bank = int'(bus.rd_bank);
        end
        len++;
      end else if (in_burst) begin
        in_burst = 0;
        if (burst_q.size() == 0) begin
          check("burst_unexpected", 1, 0);
        end else begin
          e = burst_q.pop_front();
          check("burst_len", len, e.len);
          check("burst_bank", bank, e.bank);
        end
      end
      if (fd_prev) check("frame_done_width", int'(bus.frame_done), 0);
      if (bus.frame_done) begin
        if (fd_q.size() == 0) check("frame_done_unexpected", 1, 0);
        else check("frame_done_line_cnt", int'(bus.line_cnt), fd_q.pop_front());
      end
      fd_prev = bus.frame_done;
    end
  end

  initial begin
    int n;
    sync_rst        = 1'b1;
    bus.enable      = 1'b0;
    bus.frame_start = 1'b0;
    bus.block_done  = 1'b0;
    bus.out_ready   = 1'b0;
    ticks(2);

    // Reset state
    check("rst_read_req",  int'(bus.read_req), 0);
    check("rst_rd_bank",   int'(bus.rd_bank), 0);
    check("rst_line_cnt",  int'(bus.line_cnt), 0);
    check("rst_pending",   int'(bus.pending), 0);
    check("rst_busy",      int'(bus.busy), 0);
    check("rst_frame_done", int'(bus.frame_done), 0);
    check("rst_overflow",  int'(bus.overflow_err), 0);
    check("rst_timeout",   int'(bus.timeout_err), 0);
    sync_rst = 1'b0;
    tick();

    // Full frame, banks 0,1,0; stray frame_start mid-frame ignored
    bus.enable = 1'b1;
    bus.out_ready = 1'b1;
    push_burst(0, BL); push_burst(1, BL); push_burst(0, BL);
    fd_q.push_back(LPF);
    start_frame();
    check("frame_busy", int'(bus.busy), 1);
    pulse_bd();
    check("pending_after_bd", int'(bus.pending), 1);
    wait_rr(n);
    check("read_latency", n, 1 + GC + 1);
    ticks(15);
    pulse_bd();
    ticks(5);
    start_frame();
    ticks(13);
    pulse_bd();
    ticks(20);
    check("frame_line_cnt", int'(bus.line_cnt), LPF);
    check("frame_idle", int'(bus.busy), 0);
    check("frame_pending", int'(bus.pending), 0);
    check("frame_rd_bank", int'(bus.rd_bank), 1);

    // Simultaneous write and consume with pending=1
    bus.out_ready = 1'b0;
    push_burst(0, BL); push_burst(1, BL); push_burst(0, BL);
    fd_q.push_back(LPF);
    start_frame();
    pulse_bd();
    ticks(2);
    bus.out_ready  = 1'b1;
    bus.block_done = 1'b1;
    tick();
    bus.block_done = 1'b0;
    check("simul_pending", int'(bus.pending), 1);
    ticks(30);
    check("simul_pending_drained", int'(bus.pending), 0);
    check("simul_line_cnt", int'(bus.line_cnt), 2);
    pulse_bd();
    ticks(20);
    check("simul_frame_line_cnt", int'(bus.line_cnt), LPF);

    // Overflow: third block with two already pending
    bus.out_ready = 1'b0;
    push_burst(0, BL); push_burst(1, BL); push_burst(0, BL);
    fd_q.push_back(LPF);
    start_frame();
    pulse_bd();
    ticks(2);
    pulse_bd();
    check("ovf_pending2", int'(bus.pending), 2);
    check("ovf_not_yet", int'(bus.overflow_err), 0);
    ticks(2);
    pulse_bd();
    check("ovf_set", int'(bus.overflow_err), 1);
    check("ovf_pending_sat", int'(bus.pending), 2);
    bus.out_ready = 1'b1;
    ticks(30);
    pulse_bd();
    ticks(20);
    check("ovf_sticky", int'(bus.overflow_err), 1);
    check("ovf_frame_line_cnt", int'(bus.line_cnt), LPF);

    // Enable dropped in READ cycle 3: burst completes, no frame_done
    sync_rst = 1'b1;
    tick();
    sync_rst = 1'b0;
    tick();
    check("ovf_cleared_by_rst", int'(bus.overflow_err), 0);
    push_burst(0, BL);
    start_frame();
    pulse_bd();
    wait_rr(n);
    ticks(2);
    bus.enable = 1'b0;
    ticks(12);
    check("endis_idle", int'(bus.busy), 0);
    check("endis_line_cnt", int'(bus.line_cnt), 1);
    bus.enable = 1'b1;

    // Reset in burst cycle 4: read_req drops at once
    push_burst(0, 3);
    start_frame();
    pulse_bd();
    wait_rr(n);
    ticks(3);
    sync_rst = 1'b1;
    #1;
    check("midrst_read_req", int'(bus.read_req), 0);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_line_cnt", int'(bus.line_cnt), 0);
    check("midrst_pending", int'(bus.pending), 0);
    tick();
    sync_rst = 1'b0;
    tick();
    check("postrst_idle", int'(bus.busy), 0);

    // ARM stall with no blocks
    start_frame();
    ticks(16);
    check("wd_before_limit_err", int'(bus.timeout_err), 0);
    check("wd_before_limit_busy", int'(bus.busy), 1);
    tick();
`ifdef RD_SCHED_WATCHDOG_EN
    check("wd_timeout_err", int'(bus.timeout_err), 1);
    check("wd_timeout_idle", int'(bus.busy), 0);
`else
    ticks(20);
    check("nowd_timeout_err", int'(bus.timeout_err), 0);
    check("nowd_busy", int'(bus.busy), 1);
`endif
    bus.enable = 1'b0;
    tick();
    check("arm_disable_idle", int'(bus.busy), 0);

    ticks(3);
    check("bursts_outstanding", burst_q.size(), 0);
    check("frame_done_outstanding", fd_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
